rfblackwidow_ptw: RTL and testbench

RFBLACKWIDOW_PTW -- requirements
Module: rfBlackWidow_ptw
(TLB miss handler / page-table walker; consumes TLB miss outputs, drives the TLB write port.)

---
 rtl/rfblackwidow_ptw_pkg.sv | 28 ++
 rtl/rfblackwidow_ptw.sv | 182 ++++++++++++++++++
 tb/tb_rfblackwidow_ptw.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfblackwidow_ptw_pkg.sv
// Shared address/TLB-entry types plus the page-table walker state set and PTE size.
// rfBlackWidowMmuPkg carries the walker additions; rfBlackWidowPkg holds the base address type.
package rfBlackWidowPkg;
  typedef logic [31:0] Address;
endpackage

package rfBlackWidowMmuPkg;
  import rfBlackWidowPkg::*;

  localparam int PTE_BYTES = 32;

  // Low 128 bits arrive on the first read beat, high 128 bits on the second.
  typedef struct packed {
    Address      pmtadr;
    Address      adr;
    logic [63:0] rsvd;
    logic [63:0] ppn;
    logic [31:0] vpn;
    logic [7:0]  asid;
    logic        v;
    logic        g;
    logic [21:0] flags;
  } TLBE;

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, CHECK, WRITE, FAULT, HOLD
  } ptw_state_e;
endpackage

// File: rtl/rfblackwidow_ptw.sv
// TLB miss handler: fetches a two-beat PTE, validates it and refills a round-robin TLB way.
// Define RFBW_PTW_ADR_FILL_EN to stamp the PTE fetch addresses into the written entry.
module rfblackwidow_ptw
  import rfBlackWidowPkg::*;
  import rfBlackWidowMmuPkg::*;
#(
  parameter int         AWID  = 32,
  parameter int         ASSOC = 5,
  parameter logic [7:0] TMO   = 8'd255
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              miss_i,
  input  logic [AWID-1:0]   miss_adr_i,
  input  logic [7:0]        asid_i,
  input  logic [AWID-1:0]   ptbr_i,
  output logic              m_cyc_o,
  input  logic              m_ack_i,
  output logic [AWID-1:0]   m_adr_o,
  input  logic [127:0]      m_dat_i,
  input  logic              tlb_rdy_i,
  output logic              wrtlb_o,
  output logic [15:0]       tlbadr_o,
  output TLBE               tlbdat_o,
  output logic              fault_o,
  output logic [AWID-1:0]   fault_adr_o,
  output logic              busy_o
);

  localparam logic [2:0] WAY_LAST = 3'(ASSOC - 2);

  ptw_state_e      state_q, state_d;
  logic [AWID-1:0] va_q, va_d;
  logic [AWID-1:0] mAdr_q, mAdr_d;
  logic [AWID-1:0] pteAdr_q, pteAdr_d;
  logic [AWID-1:0] faultAdr_q, faultAdr_d;
  logic            mCyc_q, mCyc_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [1:0]      hold_q, hold_d;
  logic [2:0]      way_q, way_d;
  logic            wrtlb_q, wrtlb_d;
  logic            fault_q, fault_d;
  logic [15:0]     tlbAdr_q, tlbAdr_d;
  TLBE             tlbe_q, tlbe_d;
  logic [7:0]      tmoInc;
  logic [AWID-1:0] rowOff;

  assign tmoInc = tmo_q + 8'd1;
  assign rowOff = AWID'({miss_adr_i[31:16], 5'b0});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      va_q       <= '0;
      mAdr_q     <= '0;
      pteAdr_q   <= '0;
      faultAdr_q <= '0;
      mCyc_q     <= 1'b0;
      tmo_q      <= '0;
      hold_q     <= '0;
      way_q      <= '0;
      wrtlb_q    <= 1'b0;
      fault_q    <= 1'b0;
      tlbAdr_q   <= '0;
      tlbe_q     <= '0;
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      mAdr_q     <= mAdr_d;
      pteAdr_q   <= pteAdr_d;
      faultAdr_q <= faultAdr_d;
      mCyc_q     <= mCyc_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      way_q      <= way_d;
      wrtlb_q    <= wrtlb_d;
      fault_q    <= fault_d;
      tlbAdr_q   <= tlbAdr_d;
      tlbe_q     <= tlbe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    va_d       = va_q;
    mAdr_d     = mAdr_q;
    pteAdr_d   = pteAdr_q;
    faultAdr_d = faultAdr_q;
    mCyc_d     = mCyc_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    way_d      = way_q;
    wrtlb_d    = 1'b0;
    fault_d    = 1'b0;
    tlbAdr_d   = tlbAdr_q;
    tlbe_d     = tlbe_q;

    case (state_q)
      IDLE: begin
        if (miss_i) begin
          va_d     = miss_adr_i;
          mAdr_d   = ptbr_i + rowOff;
          pteAdr_d = ptbr_i + rowOff;
          mCyc_d   = 1'b1;
          tmo_d    = '0;
          state_d  = RD0;
        end
      end
      RD0: begin
        if (m_ack_i) begin
          tlbe_d[127:0] = m_dat_i;
          mCyc_d        = 1'b0;
          state_d       = RD1;
        end else if (tmoInc == TMO) begin
          mCyc_d  = 1'b0;
          state_d = FAULT;
        end else begin
          tmo_d = tmoInc;
        end
      end
      // The first RD1 cycle is the mandatory idle gap between beats.
      RD1: begin
        if (!mCyc_q) begin
          mCyc_d = 1'b1;
          mAdr_d = pteAdr_q + AWID'(PTE_BYTES / 2);
          tmo_d  = '0;
        end else if (m_ack_i) begin
          tlbe_d[255:128] = m_dat_i;
          mCyc_d          = 1'b0;
          state_d         = CHECK;
        end else if (tmoInc == TMO) begin
          mCyc_d  = 1'b0;
          state_d = FAULT;
        end else begin
          tmo_d = tmoInc;
        end
      end
      CHECK: begin
        if (!tlbe_q.v || (!tlbe_q.g && (tlbe_q.asid != asid_i)))
          state_d = FAULT;
        else
          state_d = WRITE;
      end
      WRITE: begin
        if (tlb_rdy_i) begin
          wrtlb_d  = 1'b1;
          tlbAdr_d = {1'b0, va_q[25:16], 2'b00, way_q};
`ifdef RFBW_PTW_ADR_FILL_EN
          tlbe_d.adr    = Address'(pteAdr_q);
          tlbe_d.pmtadr = Address'(mAdr_q);
`endif
          way_d    = (way_q == WAY_LAST) ? 3'd0 : way_q + 3'd1;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      FAULT: begin
        fault_d    = 1'b1;
        faultAdr_d = va_q;
        hold_d     = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        if (hold_q == 2'd3)
          state_d = IDLE;
        else
          hold_d = hold_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_cyc_o     = mCyc_q;
  assign m_adr_o     = mAdr_q;
  assign wrtlb_o     = wrtlb_q;
  assign tlbadr_o    = tlbAdr_q;
  assign tlbdat_o    = tlbe_q;
  assign fault_o     = fault_q;
  assign fault_adr_o = faultAdr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rfblackwidow_ptw.sv
// Self-checking bench for rfblackwidow_ptw: table of directed walks plus timeout and
// asynchronous-reset sequences, with a small memory/TLB responder.
module tb_rfblackwidow_ptw;
  import rfBlackWidowPkg::*;
  import rfBlackWidowMmuPkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          miss_i;
  logic [31:0]   miss_adr_i;
  logic [7:0]    asid_i;
  logic [31:0]   ptbr_i;
  logic          m_cyc_o;
  logic          m_ack_i;
  logic [31:0]   m_adr_o;
  logic [127:0]  m_dat_i;
  logic          tlb_rdy_i;
  logic          wrtlb_o;
  logic [15:0]   tlbadr_o;
  TLBE           tlbdat_o;
  logic          fault_o;
  logic [31:0]   fault_adr_o;
  logic          busy_o;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] ptbr;
    logic [31:0] va;
    logic [7:0]  asidIn;
    logic [7:0]  pteAsid;
    logic        v;
    logic        g;
    int          ackDelay;
    int          rdyWait;
    logic        expWrite;
    logic [31:0] expAdr0;
    logic [31:0] expAdr1;
    logic [15:0] expTlbAdr;
  } vec_t;

  typedef struct {
    int          beats;
    int          gap;
    int          cycCount;
    int          wrCount;
    int          faultCount;
    int          holdLen;
    logic [31:0] adr0;
    logic [31:0] adr1;
    logic [31:0] faultAdr;
    logic [15:0] tlbAdr;
    TLBE         tlbDat;
    bit          timedOut;
    bit          busyStart;
    bit          wrEarly;
  } res_t;

  rfblackwidow_ptw dut (
    .clk_i(clk_i), .rst_i(rst_i), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
    .asid_i(asid_i), .ptbr_i(ptbr_i), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i),
    .m_adr_o(m_adr_o), .m_dat_i(m_dat_i), .tlb_rdy_i(tlb_rdy_i), .wrtlb_o(wrtlb_o),
    .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o), .fault_o(fault_o),
    .fault_adr_o(fault_adr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic TLBE makePte(input vec_t t);
    TLBE e;
    e        = '0;
    e.v      = t.v;
    e.g      = t.g;
    e.asid   = t.pteAsid;
    e.vpn    = t.va;
    e.ppn    = {32'h0000_CAFE, t.va};
    e.adr    = 32'hA5A5_0000 ^ t.va;
    e.pmtadr = 32'h5A5A_0000 ^ t.va;
    e.flags  = 22'h15555;
    return e;
  endfunction

  // Issues one miss and plays memory + TLB until the walker goes idle again.
  task automatic applyStimulus(input vec_t t, output res_t r);
    TLBE e;
    int  cnt, rdyCnt;
    bit  prevCyc, rdyOn, pulseSeen, done;
    e = makePte(t);
    r.beats = 0; r.gap = 0; r.cycCount = 0; r.wrCount = 0; r.faultCount = 0;
    r.holdLen = 0; r.adr0 = '0; r.adr1 = '0; r.faultAdr = '0; r.tlbAdr = '0;
    r.tlbDat = '0; r.timedOut = 1'b0; r.wrEarly = 1'b0;
    cnt = 0; rdyCnt = 0; prevCyc = 0; rdyOn = 0; pulseSeen = 0; done = 0;
    @(negedge clk_i);
    ptbr_i = t.ptbr; asid_i = t.asidIn; miss_adr_i = t.va; miss_i = 1'b1;
    @(negedge clk_i);
    miss_adr_i = 32'hDEAD_BEEF;
    r.busyStart = busy_o;
    for (int c = 0; c < 600; c++) begin
      m_ack_i = 1'b0;
      if (m_cyc_o) begin
        if (!prevCyc) begin
          if (r.beats == 0) r.adr0 = m_adr_o; else r.adr1 = m_adr_o;
          r.beats++;
          cnt = 0;
        end else begin
          cnt++;
        end
        r.cycCount++;
        if (cnt == t.ackDelay) begin
          m_ack_i = 1'b1;
          m_dat_i = (r.beats == 1) ? e[127:0] : e[255:128];
        end
      end else if (r.beats == 1) begin
        r.gap++;
      end
      if (wrtlb_o) begin
        r.wrCount++;
        r.tlbAdr = tlbadr_o;
        r.tlbDat = tlbdat_o;
        if (!rdyOn) r.wrEarly = 1'b1;
      end
      if (fault_o) begin
        r.faultCount++;
        r.faultAdr = fault_adr_o;
      end
      if (r.beats == 2 && !m_cyc_o && !rdyOn) begin
        if (rdyCnt == t.rdyWait) begin
          rdyOn = 1'b1;
          tlb_rdy_i = 1'b1;
        end
        rdyCnt++;
      end
      if (wrtlb_o || fault_o) begin
        pulseSeen = 1'b1;
        miss_i = 1'b0;
      end
      if (pulseSeen && busy_o) r.holdLen++;
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
      prevCyc = m_cyc_o;
      @(negedge clk_i);
    end
    r.timedOut = !done;
    m_ack_i = 1'b0; tlb_rdy_i = 1'b0; miss_i = 1'b0;
  endtask

  task automatic checkWalk(input string tag, input vec_t t, input res_t r);
    TLBE e;
    logic [31:0] expAdr, expPmt;
    e = makePte(t);
`ifdef RFBW_PTW_ADR_FILL_EN
    expAdr = t.expAdr0;
    expPmt = t.expAdr1;
`else
    expAdr = e.adr;
    expPmt = e.pmtadr;
`endif
    checkOutput({tag, " finished"}, 64'(r.timedOut), 64'(0));
    checkOutput({tag, " busy"}, 64'(r.busyStart), 64'(1));
    checkOutput({tag, " beats"}, 64'(r.beats), 64'(2));
    checkOutput({tag, " rd0 adr"}, 64'(r.adr0), 64'(t.expAdr0));
    checkOutput({tag, " rd1 adr"}, 64'(r.adr1), 64'(t.expAdr1));
    checkOutput({tag, " beat gap"}, 64'(r.gap), 64'(1));
    checkOutput({tag, " wrtlb count"}, 64'(r.wrCount), 64'(t.expWrite));
    checkOutput({tag, " fault count"}, 64'(r.faultCount), 64'(!t.expWrite));
    checkOutput({tag, " hold len"}, 64'(r.holdLen), 64'(4));
    checkOutput({tag, " wr before rdy"}, 64'(r.wrEarly), 64'(0));
    if (t.expWrite) begin
      checkOutput({tag, " tlbadr"}, 64'(r.tlbAdr), 64'(t.expTlbAdr));
      checkOutput({tag, " tlbdat asid"}, 64'(r.tlbDat.asid), 64'(t.pteAsid));
      checkOutput({tag, " tlbdat ppn"}, r.tlbDat.ppn, e.ppn);
      checkOutput({tag, " tlbdat adr"}, 64'(r.tlbDat.adr), 64'(expAdr));
      checkOutput({tag, " tlbdat pmtadr"}, 64'(r.tlbDat.pmtadr), 64'(expPmt));
    end else begin
      checkOutput({tag, " fault adr"}, 64'(r.faultAdr), 64'(t.va));
    end
  endtask

  vec_t vecs [8];
  vec_t tv, rv;
  res_t res;
  bit   acked, reached;

  initial begin
    vecs[0] = '{32'h0010_0000, 32'h1234_5678, 8'h05, 8'h05, 1'b1, 1'b1, 2, 0, 1'b1, 32'h0012_4680, 32'h0012_4690, 16'h4680};
    vecs[1] = '{32'h0010_0000, 32'h1234_5678, 8'h05, 8'h05, 1'b0, 1'b1, 2, 0, 1'b0, 32'h0012_4680, 32'h0012_4690, 16'h0000};
    vecs[2] = '{32'h0020_0000, 32'hABCD_0000, 8'h3C, 8'h3C, 1'b1, 1'b0, 0, 3, 1'b1, 32'h0035_79A0, 32'h0035_79B0, 16'h79A1};
    vecs[3] = '{32'h0020_0000, 32'h0001_0000, 8'h3D, 8'h3C, 1'b1, 1'b0, 1, 0, 1'b0, 32'h0020_0020, 32'h0020_0030, 16'h0000};
    vecs[4] = '{32'h0000_0020, 32'h0001_F000, 8'h11, 8'h22, 1'b1, 1'b1, 3, 2, 1'b1, 32'h0000_0040, 32'h0000_0050, 16'h0022};
    vecs[5] = '{32'h0010_0000, 32'hFFFF_1234, 8'h00, 8'hFF, 1'b1, 1'b1, 1, 5, 1'b1, 32'h002F_FFE0, 32'h002F_FFF0, 16'h7FE3};
    vecs[6] = '{32'h0000_0000, 32'h0002_0000, 8'h01, 8'h01, 1'b1, 1'b1, 0, 0, 1'b1, 32'h0000_0040, 32'h0000_0050, 16'h0040};
    vecs[7] = '{32'h0000_0000, 32'h0003_0000, 8'h01, 8'h01, 1'b1, 1'b1, 4, 1, 1'b1, 32'h0000_0060, 32'h0000_0070, 16'h0061};
    tv      = '{32'h0010_0000, 32'h0F0F_0000, 8'h01, 8'h01, 1'b1, 1'b1, 9999, 0, 1'b0, 32'h0011_E1E0, 32'h0, 16'h0};
    rv      = '{32'h0010_0000, 32'h0005_0000, 8'h01, 8'h02, 1'b1, 1'b1, 2, 1, 1'b1, 32'h0010_00A0, 32'h0010_00B0, 16'h00A0};

    rst_i = 1'b1; miss_i = 1'b0; miss_adr_i = '0; asid_i = '0; ptbr_i = '0;
    m_ack_i = 1'b0; m_dat_i = '0; tlb_rdy_i = 1'b0;
    #12;
    checkOutput("reset ctl", 64'({m_cyc_o, busy_o, wrtlb_o, fault_o}), 64'(0));
    checkOutput("reset m_adr", 64'(m_adr_o), 64'(0));
    checkOutput("reset tlbadr", 64'(tlbadr_o), 64'(0));
    checkOutput("reset tlbdat", 64'(tlbdat_o != '0), 64'(0));
    checkOutput("reset fault_adr", 64'(fault_adr_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], res);
      checkWalk($sformatf("v%0d", i), vecs[i], res);
    end

    // No acknowledge at all: the read must time out into a fault.
    applyStimulus(tv, res);
    checkOutput("tmo finished", 64'(res.timedOut), 64'(0));
    checkOutput("tmo beats", 64'(res.beats), 64'(1));
    checkOutput("tmo rd0 adr", 64'(res.adr0), 64'(tv.expAdr0));
    checkOutput("tmo cyc len", 64'(res.cycCount), 64'(255));
    checkOutput("tmo fault count", 64'(res.faultCount), 64'(1));
    checkOutput("tmo wrtlb count", 64'(res.wrCount), 64'(0));
    checkOutput("tmo fault adr", 64'(res.faultAdr), 64'(tv.va));
    checkOutput("tmo hold len", 64'(res.holdLen), 64'(4));

    // Drive into RD1 with the second request outstanding, then reset asynchronously.
    @(negedge clk_i);
    ptbr_i = 32'h0010_0000; miss_adr_i = 32'h0007_0000; miss_i = 1'b1;
    acked = 1'b0; reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      m_ack_i = 1'b0;
      if (m_cyc_o && !acked) begin
        m_ack_i = 1'b1;
        m_dat_i = '0;
        acked = 1'b1;
      end else if (m_cyc_o && acked) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("rst reached rd1", 64'(reached), 64'(1));
    #2 rst_i = 1'b1; miss_i = 1'b0;
    #1;
    checkOutput("async rst m_cyc", 64'(m_cyc_o), 64'(0));
    checkOutput("async rst busy", 64'(busy_o), 64'(0));
    checkOutput("async rst m_adr", 64'(m_adr_o), 64'(0));
    checkOutput("async rst tlbadr", 64'(tlbadr_o), 64'(0));
    checkOutput("async rst fault_adr", 64'(fault_adr_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    // After reset the way counter restarts at 0.
    applyStimulus(rv, res);
    checkWalk("post-rst", rv, res);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
